// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and bit-timing helper.
// Intended for reuse by both uart_tx and the uart_rx rewrite.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int BAUD_CNT_W = 16;

  // Yields 0 for an unusable ratio so the instantiating module's elaboration check trips.
  function automatic int calc_clks_per_bit(int clk_freq, int baud_rate);
    int cpb;
    cpb = (baud_rate > 0) ? clk_freq / baud_rate : 0;
    return (cpb >= 2 && cpb <= (1 << BAUD_CNT_W)) ? cpb : 0;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-producer handshake into the UART transmitter (valid/ready with an 8-bit payload).
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period clock-enable: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
// Restartable through clear so a bit boundary can be aligned to any event.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + BAUD_CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter with valid/ready byte input and registered tx/busy/ready.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  byte_if,
  output logic      tx,
  output logic      busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2 and fit the 16-bit baud counter");
  end

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_START   = ST_START;
  localparam logic [2:0] S_DATA    = ST_DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY  = ST_PARITY;
`endif
  localparam logic [2:0] S_STOP    = ST_STOP;
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [2:0]           bit_idx;
  logic                 ready_r;
  logic                 accept;
  logic                 bit_tick;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  // ready_r is only high in IDLE, so a valid while busy is simply dropped
  assign accept        = byte_if.valid && ready_r;
  assign byte_if.ready = ready_r;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (busy),
    .tick  (bit_tick)
  );

  // Payload path: loaded on accept, shifted LSB-first at each data bit end
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg  <= byte_if.data;
`ifdef UART_TX_PARITY_EN
      parity <= ^byte_if.data;
`endif
    end else if (state == S_DATA && bit_tick) begin
      shreg <= shreg >> 1;
    end
  end

  // Control path: tx is registered, so each state drives the value of the next bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      tx      <= 1'b1;
      ready_r <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_START;
            tx      <= 1'b0;
            ready_r <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (bit_tick) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              tx      <= parity;
`else
              state   <= S_STOP;
              bit_idx <= '0;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            state   <= S_STOP;
            bit_idx <= '0;
            tx      <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_tick) begin
            if (bit_idx == LAST_STOP) begin
              state   <= S_IDLE;
              ready_r <= 1'b1;
              busy    <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          tx      <= 1'b1;
          ready_r <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
